// File: rtl/tri_fetch_if.sv
// Bus bundle between the triangle fetch engine, the vertex RAM read window
// and the rasterizer triangle handshake.
interface tri_fetch_if #(
    parameter int addr_width = 8,
    parameter int data_width = 32
);
    logic                    mem_ready;
    logic [addr_width-1:0]   mem_rd_addr;
    logic [data_width-1:0]   mem_rd_data1;
    logic [data_width-1:0]   mem_rd_data2;
    logic [data_width-1:0]   mem_rd_data3;
    logic [data_width-1:0]   mem_rd_data4;
    logic [data_width-1:0]   mem_rd_data5;
    logic [data_width-1:0]   mem_rd_data6;
    logic [data_width-1:0]   mem_rd_data7;
    logic [data_width-1:0]   mem_rd_data8;
    logic [data_width-1:0]   mem_rd_data9;
    logic                    tri_valid;
    logic                    tri_ready;
    logic [9*data_width-1:0] tri_data;
    logic [7:0]              tri_index;

    modport master (
        input  mem_ready,
        output mem_rd_addr,
        input  mem_rd_data1, mem_rd_data2, mem_rd_data3,
        input  mem_rd_data4, mem_rd_data5, mem_rd_data6,
        input  mem_rd_data7, mem_rd_data8, mem_rd_data9,
        output tri_valid,
        input  tri_ready,
        output tri_data,
        output tri_index
    );

    modport slave (
        output mem_ready,
        input  mem_rd_addr,
        output mem_rd_data1, mem_rd_data2, mem_rd_data3,
        output mem_rd_data4, mem_rd_data5, mem_rd_data6,
        output mem_rd_data7, mem_rd_data8, mem_rd_data9,
        input  tri_valid,
        output tri_ready,
        input  tri_data,
        input  tri_index
    );
endinterface

// File: rtl/tri_fetch.sv
// Triangle fetch engine: walks the vertex RAM one nine-word triangle record
// at a time once the loader reports the image complete, and hands each
// registered record to the rasterizer over valid/ready.
module tri_fetch #(
    parameter int addr_width = 8,
    parameter int data_width = 32,
    parameter int TRI_COUNT  = 2,
    parameter int TRI_BASE   = 0,
    parameter int TRI_STRIDE = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    tri_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_ADDR,
        S_READ,
        S_OUT,
        S_DONE
    } state_t;

    localparam bit                    NO_TRI   = (TRI_COUNT == 0);
    localparam logic [7:0]            LAST_IDX = 8'(TRI_COUNT - 1);
    localparam logic [addr_width-1:0] BASE_A   = addr_width'(TRI_BASE);
    localparam logic [addr_width-1:0] STRIDE_A = addr_width'(TRI_STRIDE);

    state_t                  state;
    state_t                  state_nxt;
    logic [7:0]              idx;
    logic [addr_width-1:0]   rd_addr;
    logic [9*data_width-1:0] tri_data_q;
    logic [7:0]              tri_index_q;
    logic                    tri_valid_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; mem_ready only matters on the way out of IDLE/WAIT_MEM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (NO_TRI) begin
                        state_nxt = S_DONE;
                    end else if (bus.mem_ready) begin
                        state_nxt = S_ADDR;
                    end else begin
                        state_nxt = S_WAIT_MEM;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (bus.mem_ready) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                state_nxt = S_READ;
            end
            S_READ: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.tri_ready) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so tri_ready never reaches tri_valid.
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        tri_valid_c = (state == S_OUT);
    end

    // Record index, accumulated read address and the captured triangle record.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            rd_addr     <= '0;
            tri_data_q  <= '0;
            tri_index_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        rd_addr <= BASE_A;
                    end
                end
                S_READ: begin
                    tri_data_q  <= {bus.mem_rd_data9, bus.mem_rd_data8, bus.mem_rd_data7,
                                    bus.mem_rd_data6, bus.mem_rd_data5, bus.mem_rd_data4,
                                    bus.mem_rd_data3, bus.mem_rd_data2, bus.mem_rd_data1};
                    tri_index_q <= idx;
                end
                S_OUT: begin
                    // Address wraps modulo 2^addr_width by plain truncation.
                    if (bus.tri_ready && (idx != LAST_IDX)) begin
                        idx     <= idx + 8'd1;
                        rd_addr <= rd_addr + STRIDE_A;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_rd_addr = rd_addr;
    assign bus.tri_valid   = tri_valid_c;
    assign bus.tri_data    = tri_data_q;
    assign bus.tri_index   = tri_index_q;

endmodule

// File: tb/tb_tri_fetch.sv
// Bench for tri_fetch: directed timing checks on three parameterisations plus
// a randomized run of the default instance against a behavioural model.
module tb_tri_fetch;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TW = 9 * DW;
    localparam int A_COUNT  = 2;
    localparam int A_BASE   = 0;
    localparam int A_STRIDE = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [DW-1:0] ram [0:255];
    logic cmp_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tri_fetch_if #(.addr_width(AW), .data_width(DW)) bus_a ();
    tri_fetch_if #(.addr_width(AW), .data_width(DW)) bus_b ();
    tri_fetch_if #(.addr_width(AW), .data_width(DW)) bus_c ();

    tri_fetch #(.addr_width(AW), .data_width(DW), .TRI_COUNT(A_COUNT),
                .TRI_BASE(A_BASE), .TRI_STRIDE(A_STRIDE)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a));
    tri_fetch #(.addr_width(AW), .data_width(DW), .TRI_COUNT(0),
                .TRI_BASE(7), .TRI_STRIDE(9)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b));
    tri_fetch #(.addr_width(AW), .data_width(DW), .TRI_COUNT(2),
                .TRI_BASE(250), .TRI_STRIDE(9)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c), .bus(bus_c));

    // Combinational RAM read windows (index expressions wrap at 8 bits).
    always_comb begin
        bus_a.mem_rd_data1 = ram[bus_a.mem_rd_addr];
        bus_a.mem_rd_data2 = ram[bus_a.mem_rd_addr + 8'd1];
        bus_a.mem_rd_data3 = ram[bus_a.mem_rd_addr + 8'd2];
        bus_a.mem_rd_data4 = ram[bus_a.mem_rd_addr + 8'd3];
        bus_a.mem_rd_data5 = ram[bus_a.mem_rd_addr + 8'd4];
        bus_a.mem_rd_data6 = ram[bus_a.mem_rd_addr + 8'd5];
        bus_a.mem_rd_data7 = ram[bus_a.mem_rd_addr + 8'd6];
        bus_a.mem_rd_data8 = ram[bus_a.mem_rd_addr + 8'd7];
        bus_a.mem_rd_data9 = ram[bus_a.mem_rd_addr + 8'd8];
    end
    always_comb begin
        bus_b.mem_rd_data1 = ram[bus_b.mem_rd_addr];
        bus_b.mem_rd_data2 = ram[bus_b.mem_rd_addr + 8'd1];
        bus_b.mem_rd_data3 = ram[bus_b.mem_rd_addr + 8'd2];
        bus_b.mem_rd_data4 = ram[bus_b.mem_rd_addr + 8'd3];
        bus_b.mem_rd_data5 = ram[bus_b.mem_rd_addr + 8'd4];
        bus_b.mem_rd_data6 = ram[bus_b.mem_rd_addr + 8'd5];
        bus_b.mem_rd_data7 = ram[bus_b.mem_rd_addr + 8'd6];
        bus_b.mem_rd_data8 = ram[bus_b.mem_rd_addr + 8'd7];
        bus_b.mem_rd_data9 = ram[bus_b.mem_rd_addr + 8'd8];
    end
    always_comb begin
        bus_c.mem_rd_data1 = ram[bus_c.mem_rd_addr];
        bus_c.mem_rd_data2 = ram[bus_c.mem_rd_addr + 8'd1];
        bus_c.mem_rd_data3 = ram[bus_c.mem_rd_addr + 8'd2];
        bus_c.mem_rd_data4 = ram[bus_c.mem_rd_addr + 8'd3];
        bus_c.mem_rd_data5 = ram[bus_c.mem_rd_addr + 8'd4];
        bus_c.mem_rd_data6 = ram[bus_c.mem_rd_addr + 8'd5];
        bus_c.mem_rd_data7 = ram[bus_c.mem_rd_addr + 8'd6];
        bus_c.mem_rd_data8 = ram[bus_c.mem_rd_addr + 8'd7];
        bus_c.mem_rd_data9 = ram[bus_c.mem_rd_addr + 8'd8];
    end

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Literal record image when RAM word n holds n: words first..first+8, wrapping at 256.
    function automatic logic [TW-1:0] lit_win(input int first);
        logic [TW-1:0] w;
        w = '0;
        for (int j = 0; j < 9; j++) w[j*DW +: DW] = DW'((first + j) % 256);
        return w;
    endfunction

    // Record image read from the current RAM contents.
    function automatic logic [TW-1:0] ram_win(input logic [7:0] a);
        logic [TW-1:0] w;
        for (int j = 0; j < 9; j++) w[j*DW +: DW] = ram[8'(a + 8'(j))];
        return w;
    endfunction

    function automatic logic [7:0] rec_addr(input int i);
        return 8'((A_BASE + i * A_STRIDE) % 256);
    endfunction

    // Behavioural model of instance A: pass progress as wait flag, gap countdown and record number.
    logic          m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_wait = 1'b0;
    int            m_gap = 0;
    int            m_idx = 0;
    logic [7:0]    m_addr = '0;
    logic [TW-1:0] m_data = '0;
    logic [7:0]    m_index = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_wait <= 1'b0;
            m_gap <= 0; m_idx <= 0; m_addr <= '0; m_data <= '0; m_index <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (start_a) begin
                m_busy <= 1'b1;
                m_idx  <= 0;
                m_addr <= rec_addr(0);
                if (A_COUNT == 0) m_done <= 1'b1;
                else if (bus_a.mem_ready) m_gap <= 2;
                else m_wait <= 1'b1;
            end
        end else if (m_wait) begin
            if (bus_a.mem_ready) begin
                m_wait <= 1'b0;
                m_gap  <= 2;
            end
        end else if (m_gap == 2) begin
            m_gap <= 1;
        end else if (m_gap == 1) begin
            m_gap   <= 0;
            m_valid <= 1'b1;
            m_data  <= ram_win(m_addr);
            m_index <= 8'(m_idx);
        end else if (m_valid && bus_a.tri_ready) begin
            m_valid <= 1'b0;
            if (m_idx == A_COUNT - 1) begin
                m_done <= 1'b1;
            end else begin
                m_idx  <= m_idx + 1;
                m_addr <= rec_addr(m_idx + 1);
                m_gap  <= 2;
            end
        end
    end

    // Every-cycle comparison of instance A against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy_a, m_busy);
            check("done", done_a, m_done);
            check("tri_valid", bus_a.tri_valid, m_valid);
            check("mem_rd_addr", bus_a.mem_rd_addr, m_addr);
            check("tri_index", bus_a.tri_index, m_index);
            check("tri_data", bus_a.tri_data, m_data);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);
        bus_a.mem_ready = 1'b1; bus_a.tri_ready = 1'b1;
        bus_b.mem_ready = 1'b1; bus_b.tri_ready = 1'b1;
        bus_c.mem_ready = 1'b1; bus_c.tri_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst busy", busy_a, 1'b0);
        check("rst valid", bus_a.tri_valid, 1'b0);
        check("rst addr", bus_a.mem_rd_addr, 8'd0);
        check("rst data", bus_a.tri_data, '0);
        check("rst done", done_a, 1'b0);
        check("rst addr c", bus_c.mem_rd_addr, 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full pass on all three instances, tri_ready held high.
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) begin
                check("b done k+1", done_b, 1'b1);
                check("b addr", bus_b.mem_rd_addr, 8'd7);
                check("b valid", bus_b.tri_valid, 1'b0);
                check("a valid k+1", bus_a.tri_valid, 1'b0);
            end
            if (c == 2) begin
                check("b done k+2", done_b, 1'b0);
                check("b busy k+2", busy_b, 1'b0);
                check("b valid k+2", bus_b.tri_valid, 1'b0);
            end
            if (c == 3) begin
                check("a valid k+3", bus_a.tri_valid, 1'b1);
                check("a tri0 data", bus_a.tri_data, lit_win(0));
                check("a tri0 index", bus_a.tri_index, 8'd0);
                check("c addr0", bus_c.mem_rd_addr, 8'd250);
                check("c tri0 data", bus_c.tri_data, lit_win(250));
            end
            if (c == 4) check("a valid k+4", bus_a.tri_valid, 1'b0);
            if (c == 6) begin
                check("a tri1 data", bus_a.tri_data, lit_win(9));
                check("a tri1 index", bus_a.tri_index, 8'd1);
                check("c addr1 wrap", bus_c.mem_rd_addr, 8'd3);
                check("c tri1 data", bus_c.tri_data, lit_win(3));
            end
            if (c == 7) begin
                check("a done k+7", done_a, 1'b1);
                check("a busy k+7", busy_a, 1'b1);
                check("c done k+7", done_c, 1'b1);
            end
            if (c == 8) begin
                check("a busy k+8", busy_a, 1'b0);
                check("a done k+8", done_a, 1'b0);
            end
            @(negedge clk);
        end

        // Start while RAM not ready, then a 4-cycle stall in OUT.
        bus_a.mem_ready = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("wait busy", busy_a, 1'b1);
            check("wait valid", bus_a.tri_valid, 1'b0);
            check("wait addr", bus_a.mem_rd_addr, 8'd0);
            @(negedge clk);
        end
        bus_a.mem_ready = 1'b1;
        bus_a.tri_ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c < 3) check("ready lat valid lo", bus_a.tri_valid, 1'b0);
            else begin
                check("stall valid", bus_a.tri_valid, 1'b1);
                check("stall data", bus_a.tri_data, lit_win(0));
                check("stall index", bus_a.tri_index, 8'd0);
            end
        end
        bus_a.tri_ready = 1'b1;
        @(negedge clk);
        check("post accept valid", bus_a.tri_valid, 1'b0);
        repeat (6) @(negedge clk);

        // Reset while triangle 0 is presented, then a fresh pass.
        bus_a.tri_ready = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset valid", bus_a.tri_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid rst valid", bus_a.tri_valid, 1'b0);
        check("mid rst busy", busy_a, 1'b0);
        check("mid rst data", bus_a.tri_data, '0);
        check("mid rst addr", bus_a.mem_rd_addr, 8'd0);
        check("mid rst done", done_a, 1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        check("restart valid", bus_a.tri_valid, 1'b1);
        check("restart index", bus_a.tri_index, 8'd0);
        bus_a.tri_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Randomized traffic against the model with random RAM contents.
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        for (int c = 0; c < 4000; c++) begin
            reset           = ($urandom_range(0, 199) == 0);
            start_a         = ($urandom_range(0, 3) == 0);
            bus_a.mem_ready = ($urandom_range(0, 2) != 0);
            bus_a.tri_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        reset = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
